// File: rtl/mem_bridge_pkg.sv
// Shared types and default geometry for the memory request bridge.
package mem_bridge_pkg;

  localparam int DEF_ADDR_WIDTH = 16;
  localparam int DEF_DATA_WIDTH = 32;
  localparam logic [DEF_ADDR_WIDTH-1:0] DEF_PARK_ADDR = 16'h00FF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_WACK,
    ST_RD,
    ST_RCAP
  } state_t;

  // Request layout at the default widths; the bridge mirrors it at its own widths.
  typedef struct packed {
    logic                      wr;
    logic [DEF_ADDR_WIDTH-1:0] addr;
    logic [DEF_DATA_WIDTH-1:0] wdata;
  } req_t;

endpackage

// File: rtl/mem_req_fifo.sv
// Synchronous registered FIFO, head visible on pop_data; push ignored when full, pop when empty.
// Simultaneous push and pop keep level unchanged; reset empties it asynchronously.
module mem_req_fifo #(
  parameter int WIDTH = 49,
  parameter int DEPTH = 4,
  localparam int LW = $clog2(DEPTH) + 1,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] store [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full     = (level == LW'(DEPTH));
  assign empty    = (level == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = store[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) store[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/mem_req_bridge.sv
// Queues requests and plays each to memory as one strobe/address cycle plus one capture cycle.
// Accept-to-rsp_valid is 3 cycles when idle; req_ready = FIFO not full, one completion held until rsp_ready.
module mem_req_bridge
  import mem_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] PARK_ADDR = DEF_PARK_ADDR
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        req_wr,
  input  logic [ADDR_WIDTH-1:0]       req_addr,
  input  logic [DATA_WIDTH-1:0]       req_wdata,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic                        rsp_wr,
  output logic [DATA_WIDTH-1:0]       rsp_rdata,
  output logic                        rsp_ack,
  output logic                        mem_wr,
  output logic [ADDR_WIDTH-1:0]       mem_addr,
  output logic [DATA_WIDTH-1:0]       mem_wdata,
  input  logic [DATA_WIDTH-1:0]       mem_rdata,
  input  logic                        mem_response,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  typedef struct packed {
    logic                  wr;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } breq_t;

  breq_t                 push_req;
  breq_t                 head;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  pop;
  state_t                state;
  state_t                state_nxt;
  logic                  mem_wr_nxt;
  logic [ADDR_WIDTH-1:0] mem_addr_nxt;
  logic [DATA_WIDTH-1:0] mem_wdata_nxt;

  assign push_req  = '{wr: req_wr, addr: req_addr, wdata: req_wdata};
  assign req_ready = !fifo_full;
  // Holding off while a completion is pending keeps at most one response outstanding.
  assign pop       = (state == ST_IDLE) && !fifo_empty && !rsp_valid;

  mem_req_fifo #(
    .WIDTH ($bits(breq_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (req_valid),
    .push_data (push_req),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (pop) state_nxt = head.wr ? ST_WR : ST_RD;
      ST_WR:   state_nxt = ST_WACK;
      ST_WACK: state_nxt = ST_IDLE;
      ST_RD:   state_nxt = ST_RCAP;
      ST_RCAP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Memory pins are registered from the upcoming state, so they line up with it.
  always_comb begin
    mem_wr_nxt    = 1'b0;
    mem_addr_nxt  = PARK_ADDR;
    mem_wdata_nxt = mem_wdata;
    case (state_nxt)
      ST_WR: begin
        mem_wr_nxt    = 1'b1;
        mem_addr_nxt  = head.addr;
        mem_wdata_nxt = head.wdata;
      end
      ST_RD:   mem_addr_nxt = head.addr;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_wr    <= 1'b0;
      mem_addr  <= PARK_ADDR;
      mem_wdata <= '0;
    end else begin
      mem_wr    <= mem_wr_nxt;
      mem_addr  <= mem_addr_nxt;
      mem_wdata <= mem_wdata_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      rsp_wr    <= 1'b0;
      rsp_ack   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      case (state)
        ST_WACK: begin
          rsp_valid <= 1'b1;
          rsp_wr    <= 1'b1;
          rsp_ack   <= mem_response;
          rsp_rdata <= '0;
        end
        ST_RCAP: begin
          rsp_valid <= 1'b1;
          rsp_wr    <= 1'b0;
          rsp_ack   <= 1'b1;
          rsp_rdata <= mem_rdata;
        end
        default: if (rsp_valid && rsp_ready) rsp_valid <= 1'b0;
      endcase
    end
  end

endmodule
